// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN datapath read-out blocks.
//   state_t      : drain FSM encoding (IDLE=0, EMIT=1)
//   sat_hi/sat_lo: signed saturation limits for an out_bit-wide result
package cnn_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  // Largest representable signed value of an out_bit-wide word.
  function automatic int sat_hi(input int out_bit);
    return (1 << (out_bit - 1)) - 1;
  endfunction

  // Smallest representable signed value of an out_bit-wide word.
  function automatic int sat_lo(input int out_bit);
    return -(1 << (out_bit - 1));
  endfunction

endpackage

// File: rtl/requant_sat.sv
// Combinational requantizer: arithmetic right shift, optional ReLU,
// saturation to OUT_BIT. All compares happen at full ACC_BIT width.
//   x       in  ACC_BIT  signed accumulator lane
//   shift   in  5        right-shift amount
//   relu_en in  1        clamp negatives to zero
//   y       out OUT_BIT  signed requantized result
// Assumes OUT_BIT < ACC_BIT.
module requant_sat
  import cnn_pkg::*;
#(
  parameter int ACC_BIT = 20,
  parameter int OUT_BIT = 8
) (
  input  logic signed [ACC_BIT-1:0] x,
  input  logic        [4:0]         shift,
  input  logic                      relu_en,
  output logic signed [OUT_BIT-1:0] y
);

  localparam logic signed [ACC_BIT-1:0] HI = ACC_BIT'(sat_hi(OUT_BIT));
  localparam logic signed [ACC_BIT-1:0] LO = ACC_BIT'(sat_lo(OUT_BIT));

  logic signed [ACC_BIT-1:0] x_sh;
  logic signed [ACC_BIT-1:0] x_rl;

  always_comb begin
    // Sign-filling shift: shift >= ACC_BIT settles at 0 or -1.
    x_sh = x >>> shift;
    x_rl = (relu_en && x_sh < 0) ? '0 : x_sh;
    if (x_rl > HI)      y = HI[OUT_BIT-1:0];
    else if (x_rl < LO) y = LO[OUT_BIT-1:0];
    else                y = x_rl[OUT_BIT-1:0];
  end

endmodule

// File: rtl/accum_drain.sv
// Read-out stage for a bank of CH signed accumulators. A start pulse in
// IDLE snapshots every lane plus the shift/ReLU config in one cycle; the
// lanes are then requantized and streamed lane 0 first, one per
// valid/ready handshake.
//   clk, rst   clock, synchronous active-high reset
//   start      snapshot request, honoured only while idle
//   acc_in     CH*ACC_BIT flattened signed lanes (lane i at [i*ACC_BIT +: ACC_BIT])
//   shift      right-shift amount, sampled with start
//   relu_en    ReLU enable, sampled with start
//   busy       stream in progress
//   out_valid  beat available
//   out_ready  downstream accepts beat
//   out_data   signed requantized value
//   out_ch     lane index of current beat
//   out_last   beat is lane CH-1
module accum_drain
  import cnn_pkg::*;
#(
  parameter int ACC_BIT = 20,
  parameter int OUT_BIT = 8,
  parameter int CH      = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [CH*ACC_BIT-1:0]     acc_in,
  input  logic [4:0]                shift,
  input  logic                      relu_en,
  output logic                      busy,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [OUT_BIT-1:0] out_data,
  output logic [$clog2(CH)-1:0]     out_ch,
  output logic                      out_last
);

  localparam int IW = $clog2(CH);
  localparam logic [IW-1:0] LAST = IW'(CH - 1);

  state_t state, state_nxt;

  logic [CH-1:0][ACC_BIT-1:0] snap;
  logic [4:0]                 shift_q;
  logic                       relu_q;
  logic [IW-1:0]              idx, idx_inc;
  logic signed [OUT_BIT-1:0]  data_q;
  logic                       last_q;

  logic                       load, adv;
  logic signed [ACC_BIT-1:0]  rq_x;
  logic [4:0]                 rq_shift;
  logic                       rq_relu;
  logic signed [OUT_BIT-1:0]  rq_y;

  // Guarded increment so a non-power-of-two CH never indexes past the bank.
  assign idx_inc = (idx == LAST) ? '0 : idx + 1'b1;

  // Single requantizer: on a start it sees lane 0 straight from the inputs
  // (snapshot not yet registered); while emitting it sees the next lane.
  always_comb begin
    if (state == IDLE) begin
      rq_x     = $signed(acc_in[ACC_BIT-1:0]);
      rq_shift = shift;
      rq_relu  = relu_en;
    end else begin
      rq_x     = $signed(snap[idx_inc]);
      rq_shift = shift_q;
      rq_relu  = relu_q;
    end
  end

  requant_sat #(.ACC_BIT(ACC_BIT), .OUT_BIT(OUT_BIT)) u_rq (
    .x       (rq_x),
    .shift   (rq_shift),
    .relu_en (rq_relu),
    .y       (rq_y)
  );

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    adv       = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_nxt = EMIT;
        load      = 1'b1;
      end
      EMIT: if (out_ready) begin
        if (idx == LAST) state_nxt = IDLE;
        else             adv       = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      snap    <= '0;
      shift_q <= '0;
      relu_q  <= 1'b0;
      idx     <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load) begin
        snap    <= acc_in;
        shift_q <= shift;
        relu_q  <= relu_en;
        idx     <= '0;
        data_q  <= rq_y;
        last_q  <= 1'b0;
      end else if (adv) begin
        idx    <= idx_inc;
        data_q <= rq_y;
        last_q <= (idx_inc == LAST);
      end
    end
  end

  assign busy      = (state == EMIT);
  assign out_valid = (state == EMIT);
  assign out_data  = data_q;
  assign out_ch    = idx;
  assign out_last  = last_q;

endmodule
